// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for RAM port B: the RS5 data port (m0) and a second
// bus master (m1) share one port with 0-cycle grant and 1-cycle read data.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   : contested, non-starved cycles alternate against last grant
//   undefined : contested, non-starved cycles always grant m0
//
// Ports:
//   clk, reset_n          : clock (rising edge), async active-low reset
//   mN_req_i              : request, held until mN_gnt_o
//   mN_we_i/addr_i/data_i : byte enables (0 = read), byte address, wdata
//   mN_gnt_o              : accepted this cycle (combinational)
//   mN_rvalid_o/data_o    : read response, one cycle after grant
//   mem_en_o/we_o/addr_o/data_o : RAM port B request
//   mem_data_i            : RAM port B read data, one cycle after mem_en_o
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req_i,
  input  logic [3:0]            m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [31:0]           m0_data_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_data_o,
  input  logic                  m1_req_i,
  input  logic [3:0]            m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [31:0]           m1_data_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_data_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          last_q,  last_d;
  logic          owner_q, owner_d;
  logic          rd_q,    rd_d;
  logic [CW-1:0] cnt0_q,  cnt0_d;
  logic [CW-1:0] cnt1_q,  cnt1_d;

  logic both;
  logic sat0;
  logic sat1;
  logic tie1;
  logic pick1;
  logic gnt0;
  logic gnt1;
  logic gnt_any;

  assign both = m0_req_i & m1_req_i;
  assign sat0 = (cnt0_q == LIMIT);
  assign sat1 = (cnt1_q == LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
  // last_q==1 means m1 was granted last, so m0 is owed the next turn.
  assign tie1 = ~last_q;
`else
  assign tie1 = 1'b0;
`endif

  always_comb begin
    pick1 = 1'b0;
    if (!both) begin
      pick1 = m1_req_i;
    end else if (sat0) begin
      pick1 = 1'b0;
    end else if (sat1) begin
      pick1 = 1'b1;
    end else begin
      pick1 = tie1;
    end
  end

  // Grants are masked while reset is held so no access reaches the RAM.
  assign gnt0    = reset_n & m0_req_i & ~pick1;
  assign gnt1    = reset_n & m1_req_i & pick1;
  assign gnt_any = gnt0 | gnt1;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    mem_en_o   = gnt_any;
    mem_we_o   = 4'b0000;
    mem_addr_o = m0_addr_i;
    mem_data_o = m0_data_i;
    if (pick1) begin
      mem_addr_o = m1_addr_i;
      mem_data_o = m1_data_i;
    end
    if (gnt1) begin
      mem_we_o = m1_we_i;
    end else if (gnt0) begin
      mem_we_o = m0_we_i;
    end
  end

  always_comb begin
    last_d  = gnt_any ? pick1 : last_q;
    rd_d    = gnt_any && (mem_we_o == 4'b0000);
    owner_d = rd_d ? pick1 : owner_q;

    cnt0_d = '0;
    if (m0_req_i && !gnt0) begin
      cnt0_d = sat0 ? cnt0_q : cnt0_q + 1'b1;
    end

    cnt1_d = '0;
    if (m1_req_i && !gnt1) begin
      cnt1_d = sat1 ? cnt1_q : cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign m0_rvalid_o = rd_q & ~owner_q;
  assign m1_rvalid_o = rd_q & owner_q;
  assign m0_data_o   = m0_rvalid_o ? mem_data_i : 32'h0;
  assign m1_data_o   = m1_rvalid_o ? mem_data_i : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed vectors push expected
// read data per master; a monitor pops and compares on each rvalid.
module tb_ram_port_arbiter;

  localparam int AW = 16;

  logic          clk;
  logic          reset_n;
  logic          m0_req, m1_req;
  logic [3:0]    m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wd, m1_wd;
  logic          m0_gnt, m1_gnt;
  logic          m0_rv, m1_rv;
  logic [31:0]   m0_rd, m1_rd;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [31:0]   mem_rd;

  int n_chk;
  int n_fail;
  logic [31:0] exp0, exp1;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] ram [0:1023];

  ram_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_data_i(m0_wd), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv),
    .m0_data_o(m0_rd),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_data_i(m1_wd), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv),
    .m1_data_o(m1_rd),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_wd), .mem_data_i(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port B model: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (!reset_n) begin
      ram[16] <= 32'hDEADBEEF;
      ram[32] <= 32'hCAFEF00D;
      ram[64] <= 32'h12345678;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_rd <= ram[mem_addr[11:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wd[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic e0, input logic e1, input string nm);
    @(negedge clk);
    chk({nm, "_gnt0"}, 32'(m0_gnt), 32'(e0));
    chk({nm, "_gnt1"}, 32'(m1_gnt), 32'(e1));
    chk({nm, "_en"}, 32'(mem_en), 32'(e0 | e1));
    if (e1) begin
      chk({nm, "_we"}, 32'(mem_we), 32'(m1_we));
      chk({nm, "_addr"}, 32'(mem_addr), 32'(m1_addr));
      if (m1_we != 4'b0000) chk({nm, "_wd"}, mem_wd, m1_wd);
      else q1.push_back(exp1);
    end else if (e0) begin
      chk({nm, "_we"}, 32'(mem_we), 32'(m0_we));
      chk({nm, "_addr"}, 32'(mem_addr), 32'(m0_addr));
      if (m0_we != 4'b0000) chk({nm, "_wd"}, mem_wd, m0_wd);
      else q0.push_back(exp0);
    end else begin
      chk({nm, "_we_idle"}, 32'(mem_we), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest expected read.
  initial begin
    forever begin
      @(negedge clk);
      if (m0_rv) begin
        if (q0.size() == 0) chk("m0_spurious_rvalid", 32'(m0_rv), 32'h0);
        else chk("m0_rdata", m0_rd, q0.pop_front());
      end else begin
        chk("m0_data_idle", m0_rd, 32'h0);
      end
      if (m1_rv) begin
        if (q1.size() == 0) chk("m1_spurious_rvalid", 32'(m1_rv), 32'h0);
        else chk("m1_rdata", m1_rd, q1.pop_front());
      end else begin
        chk("m1_data_idle", m1_rd, 32'h0);
      end
    end
  end

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    m0_req  = 1'b1;
    m1_req  = 1'b0;
    m0_we   = 4'b0000;
    m1_we   = 4'b0000;
    m0_addr = 16'h0040;
    m1_addr = 16'h0080;
    m0_wd   = 32'h0;
    m1_wd   = 32'h0;
    exp0    = 32'hDEADBEEF;
    exp1    = 32'hCAFEF00D;

    @(negedge clk);
    chk("rst_gnt0", 32'(m0_gnt), 32'h0);
    chk("rst_en", 32'(mem_en), 32'h0);
    chk("rst_rvalid0", 32'(m0_rv), 32'h0);
    chk("rst_rvalid1", 32'(m1_rv), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m0_req  = 1'b0;

    // Single-master read
    m0_req = 1'b1;
    step(1'b1, 1'b0, "rd0");
    m0_req = 1'b0;
    step(1'b0, 1'b0, "idle0");

    // Partial write from m1, then read back
    m1_req  = 1'b1;
    m1_we   = 4'b0011;
    m1_addr = 16'h0100;
    m1_wd   = 32'h0000ABCD;
    step(1'b0, 1'b1, "wr1");
    m1_we = 4'b0000;
    exp1  = 32'h1234ABCD;
    step(1'b0, 1'b1, "rdwr1");
    m1_req  = 1'b0;
    m1_addr = 16'h0080;
    exp1    = 32'hCAFEF00D;
    step(1'b0, 1'b0, "idle1");

    // Continuous contention; last grant was m1
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      step(i % 2 == 0, i % 2 == 1, $sformatf("rr%0d", i));
`else
      step(i % 5 != 4, i % 5 == 4, $sformatf("fp%0d", i));
`endif
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step(1'b0, 1'b0, "idle2");

`ifndef ARB_ROUND_ROBIN_EN
    // Withdrawal clears m1's wait count
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $sformatf("wd_a%0d", i));
    m1_req = 1'b0;
    step(1'b1, 1'b0, "wd_drop");
    m1_req = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $sformatf("wd_b%0d", i));
    step(1'b0, 1'b1, "wd_win");
    m0_req = 1'b0;
    m1_req = 1'b0;
    step(1'b0, 1'b0, "idle3");
`endif

    // Reset during the response cycle of an m0 read
    m0_req = 1'b1;
    @(negedge clk);
    chk("mr_gnt0", 32'(m0_gnt), 32'h1);
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    chk("mr_rvalid_pre", 32'(m0_rv), 32'h1);
    chk("mr_data_pre", m0_rd, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1;
    chk("mr_rvalid_rst", 32'(m0_rv), 32'h0);
    chk("mr_data_rst", m0_rd, 32'h0);
    m0_req = 1'b1;
    m1_req = 1'b1;
    @(negedge clk);
    chk("mr_gnt0_rst", 32'(m0_gnt), 32'h0);
    chk("mr_gnt1_rst", 32'(m1_gnt), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b0, "post_rst");
    m0_req = 1'b0;
    m1_req = 1'b0;
    step(1'b0, 1'b0, "idle4");
    step(1'b0, 1'b0, "idle5");

    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single data port (port B) of the on-chip RAM between the RS5 core data interface and a second bus master, such as a DMA engine or debug loader. It sits between the masters and the RAM, one level below the testbench/SoC address decoder's `enable_ram` path. It issues at most one access per cycle and routes the one-cycle-latency read data back to the requester that issued it. A per-requester wait counter bounds starvation.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, RAM byte-address width (`$clog2(MEM_WIDTH)` for `MEM_WIDTH`=65_536).
- `STARVE_LIMIT`, 4, consecutive denied cycles after which a waiting requester is forced to win. Legal range is 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_req_i` / `m1_req_i` in 1: access request, held until granted.
- `m0_we_i` / `m1_we_i` in 4: byte write enables; 0 means read.
- `m0_addr_i` / `m1_addr_i` in `ADDR_WIDTH`: byte address.
- `m0_data_i` / `m1_data_i` in 32: write data.
- `m0_gnt_o` / `m1_gnt_o` out 1: access accepted this cycle (combinational).
- `m0_rvalid_o` / `m1_rvalid_o` out 1: read data valid (registered).
- `m0_data_o` / `m1_data_o` out 32: read data.
- `mem_en_o` out 1, `mem_we_o` out 4, `mem_addr_o` out `ADDR_WIDTH`, `mem_data_o` out 32: RAM port B request.
- `mem_data_i` in 32: RAM port B read data, valid one cycle after `mem_en_o`.

## Operation
- Grant selection each cycle:
  - Only one requester: it is granted.
  - Both requesting: a requester whose wait counter equals `STARVE_LIMIT` wins. If both are saturated, m0 wins.
  - Otherwise the tie-break policy decides (see Configuration).
- Exactly one `mN_gnt_o` is high when any request is present. Both are low when there is no request or while `reset_n`=0.
- The granted master's `we`/`addr`/`data` drive `mem_*_o`, and `mem_en_o` is high. With no grant, `mem_en_o`=0 and `mem_we_o`=0; `mem_addr_o`/`mem_data_o` are don't-care.
- `last_r` (1 bit) records the most recent grant, updated on every grant.
- Wait counters, `ceil(log2(STARVE_LIMIT+1))` bits, one per requester:
  - Increment on each cycle the requester is high and not granted, saturating at `STARVE_LIMIT`.
  - Clear on grant or when the request is low.
- Read tracking: on a granted read (`we`==0), `owner_r`<=granted id and `rd_r`<=1; otherwise `rd_r`<=0. Writes produce no `rvalid`.
- `mN_rvalid_o` = `rd_r && owner_r==N`. `mN_data_o` = `mem_data_i` when that `rvalid` is high, else 0.

## Timing
- Grant latency is 0 cycles: the request and grant are in the same cycle, and the RAM is accessed on that rising edge.
- Read data arrives exactly 1 cycle after the grant, with a single `rvalid` pulse.
- Back-to-back grants to alternating masters are allowed every cycle. The response of cycle n and the grant of cycle n+1 coexist without interference.
- A requester must hold `req`/`we`/`addr`/`data` stable until `gnt`. Dropping `req` before grant is legal and clears its wait counter.
- Reset values: `last_r`=1 (so m0 wins the first contested cycle), `owner_r`=0, `rd_r`=0, counters 0, all `rvalid`=0, all `data_o`=0.
- Reset asserted mid-read clears `rd_r` immediately. No `rvalid` is emitted after reset, even if the RAM returns data.
- A requester saturated at `STARVE_LIMIT` is guaranteed a grant on the next cycle it requests, unless the other requester is also saturated, in which case m0 wins.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: a contested, non-starved cycle grants the requester that is not `last_r`, so masters strictly alternate under continuous contention.
- `ARB_ROUND_ROBIN_EN` undefined: a contested, non-starved cycle always grants m0. m1 progresses only through the starvation counter, receiving one grant per `STARVE_LIMIT`+1 contested cycles.
- All other behaviour is identical in both builds.

## Test plan
- Single-master read: m0 read of addr 0x0040 with RAM word 0xDEADBEEF → `m0_gnt_o`=1 in cycle 0; `m0_rvalid_o`=1 and `m0_data_o`=0xDEADBEEF in cycle 1; m1 outputs stay 0.
- Round robin (`ARB_ROUND_ROBIN_EN`): both masters read continuously for 6 cycles from reset → grants m0,m1,m0,m1,m0,m1; each `rvalid` arrives one cycle after its grant with the correct data.
- Fixed priority with `STARVE_LIMIT`=4: both request continuously → m0 is granted for cycles 0-3, m1 for cycle 4, then m0 again; the pattern repeats every 5 cycles.
- Write: m1 with `we`=4'b0011 to addr 0x0100 and data 0x0000ABCD → `mem_we_o`=0011 with matching addr/data in the grant cycle, no `rvalid`; a later read returns the updated low half.
- Reset mid-read: assert `reset_n`=0 in the cycle after an m0 read grant → `m0_rvalid_o` falls immediately; after release, the first contested cycle grants m0.
- Request withdrawal: m1 waits 3 cycles, drops `req` for 1 cycle, then re-requests under m0 contention (fixed priority) → m1 needs another 4 denied cycles before it is granted.
